// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial add sequencer driving one external 1-bit full-adder slice
// Optional signed-overflow output ovf_o is built when SERIAL_ADD_OVF_EN is defined.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf_o,
`endif
    output logic             fa_a_o,
    output logic             fa_b_o,
    output logic             fa_cin_o,
    input  logic             fa_sum_i,
    input  logic             fa_cout_i
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sum_sh_d  = sum_sh_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        bit_cnt_d = bit_cnt_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d     = ovf_q;
`endif
        busy_o    = 1'b0;
        done_o    = 1'b0;
        fa_a_o    = 1'b0;
        fa_b_o    = 1'b0;
        fa_cin_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_sh_d    = op_a_i;
                    b_sh_d    = op_b_i;
                    carry_d   = cin_i;
                    bit_cnt_d = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                busy_o    = 1'b1;
                fa_a_o    = a_sh_q[0];
                fa_b_o    = b_sh_q[0];
                fa_cin_o  = carry_q;
                a_sh_d    = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d    = {1'b0, b_sh_q[WIDTH-1:1]};
                sum_sh_d  = {fa_sum_i, sum_sh_q[WIDTH-1:1]};
                carry_d   = fa_cout_i;
                bit_cnt_d = bit_cnt_q + CW'(1);
                // Final bit: publish the result so it is stable for the whole DONE cycle
                if (bit_cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = sum_sh_d;
                    cout_d  = fa_cout_i;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = carry_q ^ fa_cout_i;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            sum_sh_q  <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            bit_cnt_q <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            sum_sh_q  <= sum_sh_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
            bit_cnt_q <= bit_cnt_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf_o  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl (WIDTH=8)
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, cin;
    logic [W-1:0] op_a, op_b;
    logic         busy, done, cout;
    logic [W-1:0] sum;
    logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Gate-level full-adder slice stand-in
    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_a_i(op_a), .op_b_i(op_b), .cin_i(cin),
        .busy_o(busy), .done_o(done), .sum_o(sum), .cout_o(cout),
`ifdef SERIAL_ADD_OVF_EN
        .ovf_o(ovf),
`endif
        .fa_a_o(fa_a), .fa_b_o(fa_b), .fa_cin_o(fa_cin), .fa_sum_i(fa_sum), .fa_cout_i(fa_cout)
    );

    // Launches one add and observes it; all judging is done by the callers
    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          output logic [W-1:0] s, output logic co, output logic o,
                          output int busy_n, output int done_e, output logic all_cout,
                          output logic done_after, output logic fa_idle);
        int e;
        @(negedge clk);
        op_a = a; op_b = b; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e = 0; busy_n = 0; done_e = -1; all_cout = 1'b1;
        s = 'x; co = 1'bx; o = 1'bx;
        while (e < 40 && done_e < 0) begin
            if (busy) begin
                busy_n++;
                if (!fa_cout) all_cout = 1'b0;
            end
            if (done) begin
                done_e = e;
                s = sum; co = cout;
`ifdef SERIAL_ADD_OVF_EN
                o = ovf;
`else
                o = 1'b0;
`endif
            end else begin
                @(negedge clk);
                e++;
            end
        end
        @(negedge clk);
        done_after = done;
        fa_idle    = fa_a | fa_b | fa_cin;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; op_a = 8'h05; op_b = 8'h06; cin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        n_checks++;
        if ({busy, done, cout, fa_a, fa_b, fa_cin} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {busy, done, cout, fa_a, fa_b, fa_cin});
        end
        n_checks++;
        if (sum !== 8'h00) begin
            n_fail++; $display("FAIL reset_sum: got %h expected 00", sum);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_beats_start: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] s; logic co, o, allc, da, fi; int bn, de;
        do_add(8'h0F, 8'h01, 1'b0, s, co, o, bn, de, allc, da, fi);
        n_checks++; if (bn !== 8) begin n_fail++; $display("FAIL busy_len: got %0d expected 8", bn); end
        n_checks++; if (de !== 8) begin n_fail++; $display("FAIL done_latency: got %0d expected 8", de); end
        n_checks++; if ({co, s} !== 9'h010) begin n_fail++; $display("FAIL sum_0F_01: got %h expected 010", {co, s}); end
        n_checks++; if (da !== 1'b0) begin n_fail++; $display("FAIL done_width: done still %b, expected 0", da); end
        n_checks++; if (fi !== 1'b0) begin n_fail++; $display("FAIL fa_idle: got %b expected 0", fi); end
        do_add(8'hFF, 8'h01, 1'b0, s, co, o, bn, de, allc, da, fi);
        n_checks++; if ({co, s} !== 9'h100) begin n_fail++; $display("FAIL sum_FF_01: got %h expected 100", {co, s}); end
        n_checks++; if (allc !== 1'b1) begin n_fail++; $display("FAIL fa_cout_chain: got %b expected 1", allc); end
        do_add(8'h7F, 8'h00, 1'b1, s, co, o, bn, de, allc, da, fi);
        n_checks++; if ({co, s} !== 9'h080) begin n_fail++; $display("FAIL sum_7F_cin: got %h expected 080", {co, s}); end
`ifdef SERIAL_ADD_OVF_EN
        n_checks++; if (o !== 1'b1) begin n_fail++; $display("FAIL ovf_7F_cin: got %b expected 1", o); end
`endif
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, s, es; logic c, co, o, allc, da, fi, eco, eo; int bn, de;
        for (int i = 0; i < 16; i++) begin
            a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            {eco, es} = {1'b0, a} + {1'b0, b} + {8'h00, c};
            eo = (a[W-1] == b[W-1]) && (es[W-1] != a[W-1]);
            do_add(a, b, c, s, co, o, bn, de, allc, da, fi);
            n_checks++;
            if ({co, s} !== {eco, es} || bn !== 8 || de !== 8) begin
                n_fail++;
                $display("FAIL rand_add %h+%h+%b: got %h busy %0d done@%0d expected %h busy 8 done@8",
                         a, b, c, {co, s}, bn, de, {eco, es});
            end
`ifdef SERIAL_ADD_OVF_EN
            n_checks++;
            if (o !== eo) begin n_fail++; $display("FAIL rand_ovf %h+%h+%b: got %b expected %b", a, b, c, o, eo); end
`else
            if (eo === 1'bx) $display("unreachable");
`endif
        end
    endtask

    task automatic test_ignore_mid_run();
        int e;
        @(negedge clk);
        op_a = 8'h01; op_b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        op_a = 8'hAA; op_b = 8'h55; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e = 0;
        while (!done && e < 40) begin @(negedge clk); e++; end
        n_checks++;
        if ({done, cout, sum} !== 10'h202) begin
            n_fail++; $display("FAIL ignore_mid_run: done/cout/sum got %h expected 202", {done, cout, sum});
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (sum !== 8'h02 || busy !== 1'b0) begin
                n_fail++; $display("FAIL hold_idle[%0d]: sum %h busy %b expected 02 0", k, sum, busy);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] s; logic co, o, allc, da, fi; int bn, de; int seen;
        @(negedge clk);
        op_a = 8'hFF; op_b = 8'hFF; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({busy, done, cout, sum, fa_a, fa_b, fa_cin} !== 13'h0) begin
            n_fail++; $display("FAIL abort_state: busy %b done %b cout %b sum %h fa %b%b%b expected all 0",
                               busy, done, cout, sum, fa_a, fa_b, fa_cin);
        end
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d active cycles expected 0", seen); end
        do_add(8'h03, 8'h04, 1'b0, s, co, o, bn, de, allc, da, fi);
        n_checks++;
        if ({co, s} !== 9'h007) begin n_fail++; $display("FAIL after_abort: got %h expected 007", {co, s}); end
    endtask

    task automatic test_back_to_back();
        int idx[$];
        int bad;
        @(negedge clk);
        op_a = 8'h12; op_b = 8'h34; cin = 1'b0; start = 1'b1;
        bad = 0;
        for (int t = 0; t < 45; t++) begin
            @(negedge clk);
            if (done) begin
                idx.push_back(t);
                if (sum !== 8'h46) bad++;
            end
        end
        start = 1'b0;
        n_checks++;
        if (idx.size() !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d expected 4", idx.size()); end
        for (int k = 1; k < idx.size(); k++) begin
            n_checks++;
            if (idx[k] - idx[k-1] !== 10) begin
                n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d expected 10", k, idx[k] - idx[k-1]);
            end
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL b2b_sum: got %0d wrong results expected 0", bad); end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_mid_run();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
